instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/pc_counter.sv | 42 ++++
 rtl/instr_fetch.sv | 123 ++++++++++++
 tb/tb_instr_fetch.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcode values, the fetch-unit
// state encoding and the decode of what an issued instruction does to the PC.
package cpu_pkg;

  // Opcode field values, instruction bits [7:5]
  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  // Fetch-unit FSM states
  typedef enum logic [2:0] {
    FS_IDLE  = 3'd0,
    FS_FETCH = 3'd1,
    FS_WAIT  = 3'd2,
    FS_ISSUE = 3'd3,
    FS_HALT  = 3'd4
  } fetch_state_t;

  // PC effect of an instruction at the moment the controller accepts it
  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_LOAD = 2'd1,
    PC_SKIP = 2'd2
  } issue_pc_t;

  // JMP reloads the PC, SKZ skips one byte only when the accumulator is
  // zero; everything else (including HLT) leaves the PC alone.
  function automatic issue_pc_t issue_pc_action(input logic [2:0] op,
                                                input logic       acc_zero);
    issue_pc_t act;
    act = PC_HOLD;
    if (op == OP_JMP) begin
      act = PC_LOAD;
    end else if (op == OP_SKZ && acc_zero) begin
      act = PC_SKIP;
    end
    return act;
  endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter with a load port and two independent +1 requests.
// inc is the post-fetch increment, inc2 the SKZ skip; both are modulo
// 2^ADDR_W so the counter wraps silently at the top of program memory.
module pc_counter #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  input  logic              inc2,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_next;

  // Next PC: a load wins over any increment; simultaneous increments add 2
  always_comb begin
    pc_next = pc_reg;
    if (load) begin
      pc_next = load_val;
    end else if (inc && inc2) begin
      pc_next = pc_reg + ADDR_W'(2);
    end else if (inc || inc2) begin
      pc_next = pc_reg + ADDR_W'(1);
    end
  end

  // PC register, cleared by the synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg <= '0;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads one byte per instruction from program memory,
// holds it in IR and offers it to the controller with a valid/ready
// handshake. The handshake also resolves HLT, JMP and SKZ, so the controller
// never has to touch the PC for control flow.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              resume,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_rvalid,
  output logic [OP_W-1:0]   opcode,
  output logic [ADDR_W-1:0] operand,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              acc_zero,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  fetch_state_t      state_reg;
  logic [7:0]        ir_reg;
  logic              mem_rd_reg;
  logic              instr_valid_reg;
  logic              halted_reg;

  logic              handshake;
  logic [2:0]        op_field;
  issue_pc_t         pc_action;
  logic              pc_load;
  logic              pc_inc;
  logic              pc_inc2;
  logic [ADDR_W-1:0] pc_val;

  assign op_field  = ir_reg[7:5];
  assign handshake = (state_reg == FS_ISSUE) && instr_ready;
  assign pc_action = issue_pc_action(op_field, acc_zero);

  // PC controls are qualified by state, so stray rvalid/ready/acc_zero
  // outside WAIT or ISSUE cannot move the PC.
  assign pc_inc  = (state_reg == FS_WAIT) && mem_rvalid;
  assign pc_load = handshake && (pc_action == PC_LOAD);
  assign pc_inc2 = handshake && (pc_action == PC_SKIP);

  pc_counter #(
    .ADDR_W(ADDR_W)
  ) u_pc_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pc_load),
    .load_val (operand),
    .inc      (pc_inc),
    .inc2     (pc_inc2),
    .pc       (pc_val)
  );

  // Fetch FSM; every output is registered alongside the state transition
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= FS_IDLE;
      ir_reg          <= '0;
      mem_rd_reg      <= 1'b0;
      instr_valid_reg <= 1'b0;
      halted_reg      <= 1'b1;
    end else begin
      case (state_reg)
        FS_IDLE, FS_HALT: begin
          if (resume) begin
            state_reg  <= FS_FETCH;
            mem_rd_reg <= 1'b1;
            halted_reg <= 1'b0;
          end
        end
        FS_FETCH: begin
          // Single-cycle read strobe; the reply is collected in WAIT
          state_reg  <= FS_WAIT;
          mem_rd_reg <= 1'b0;
        end
        FS_WAIT: begin
          // No timeout: memory latency is unbounded
          if (mem_rvalid) begin
            ir_reg          <= mem_rdata;
            state_reg       <= FS_ISSUE;
            instr_valid_reg <= 1'b1;
          end
        end
        FS_ISSUE: begin
          if (instr_ready) begin
            instr_valid_reg <= 1'b0;
            if (op_field == OP_HLT) begin
              state_reg  <= FS_HALT;
              halted_reg <= 1'b1;
            end else begin
              state_reg  <= FS_FETCH;
              mem_rd_reg <= 1'b1;
            end
          end
        end
        default: begin
          state_reg       <= FS_IDLE;
          mem_rd_reg      <= 1'b0;
          instr_valid_reg <= 1'b0;
          halted_reg      <= 1'b1;
        end
      endcase
    end
  end

  assign mem_rd      = mem_rd_reg;
  assign mem_addr    = pc_val;
  assign pc          = pc_val;
  assign opcode      = ir_reg[7 -: OP_W];
  assign operand     = ADDR_W'(ir_reg[7-OP_W:0]);
  assign instr_valid = instr_valid_reg;
  assign halted      = halted_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a 32-byte program memory answering each
// read strobe one cycle later, plus a way to inject stray rvalid pulses.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       resume = 1'b0;
  logic       mem_rd;
  logic [4:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_rvalid;
  logic [2:0] opcode;
  logic [4:0] operand;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic       acc_zero = 1'b0;
  logic [4:0] pc;
  logic       halted;

  logic [7:0] mem [0:31];
  logic       mem_auto = 1'b1;
  logic       auto_rvalid = 1'b0;
  logic [7:0] auto_rdata = 8'h00;
  logic       force_rvalid = 1'b0;
  logic [7:0] force_rdata = 8'h00;

  int total = 0;
  int bad = 0;
  int rd_count = 0;

  assign mem_rvalid = auto_rvalid | force_rvalid;
  assign mem_rdata  = force_rvalid ? force_rdata : auto_rdata;

  instr_fetch #(.ADDR_W(5), .OP_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .resume      (resume),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .opcode      (opcode),
    .operand     (operand),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .acc_zero    (acc_zero),
    .pc          (pc),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Memory model with one-cycle read latency, and a read-strobe counter
  always @(posedge clk) begin
    auto_rvalid <= mem_auto && mem_rd;
    auto_rdata  <= mem[mem_addr];
    if (mem_rd) rd_count <= rd_count + 1;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    resume = 1'b0;
    instr_ready = 1'b0;
    acc_zero = 1'b0;
    force_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_resume();
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
  endtask

  task automatic handshake(input logic acc);
    instr_ready = 1'b1;
    acc_zero = acc;
    @(negedge clk);
    instr_ready = 1'b0;
    acc_zero = 1'b0;
  endtask

  task automatic wait_issue(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int rd0;
    do_reset();
    total++;
    if ({halted, instr_valid, mem_rd} !== 3'b100) begin
      bad++; $display("FAIL reset_flags: got %b want 100", {halted, instr_valid, mem_rd});
    end
    total++;
    if (pc !== 5'd0) begin
      bad++; $display("FAIL reset_pc: got %0d want 0", pc);
    end
    total++;
    if ({opcode, operand} !== 8'h00) begin
      bad++; $display("FAIL reset_ir: got %h want 00", {opcode, operand});
    end
    // reset beats resume and ready in the same cycle
    rst_n = 1'b0; resume = 1'b1; instr_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; resume = 1'b0; instr_ready = 1'b0;
    total++;
    if ({halted, mem_rd} !== 2'b10) begin
      bad++; $display("FAIL reset_prio: got %b want 10", {halted, mem_rd});
    end
    // IDLE stays put without resume
    rd0 = rd_count;
    repeat (3) @(negedge clk);
    total++;
    if (rd_count != rd0 || halted !== 1'b1) begin
      bad++; $display("FAIL idle_hold: reads=%0d halted=%b want 0 1", rd_count - rd0, halted);
    end
  endtask

  task automatic test_first_fetch();
    bit ok;
    int rd0;
    mem[0] = 8'hA3;
    do_reset();
    rd0 = rd_count;
    pulse_resume();
    total++;
    if ({mem_rd, mem_addr, halted} !== {1'b1, 5'd0, 1'b0}) begin
      bad++; $display("FAIL fetch0_strobe: rd=%b addr=%0d halted=%b want 1 0 0", mem_rd, mem_addr, halted);
    end
    wait_issue(ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL fetch0_timeout: instr_valid=%b want 1", instr_valid);
    end
    total++;
    if ({opcode, operand, pc} !== {3'd5, 5'd3, 5'd1}) begin
      bad++; $display("FAIL fetch0_issue: op=%0d opd=%0d pc=%0d want 5 3 1", opcode, operand, pc);
    end
    total++;
    if (rd_count - rd0 != 1) begin
      bad++; $display("FAIL fetch0_reads: got %0d want 1", rd_count - rd0);
    end
    // resume in ISSUE is ignored
    pulse_resume();
    @(negedge clk);
    total++;
    if ({instr_valid, opcode, mem_rd} !== {1'b1, 3'd5, 1'b0} || rd_count - rd0 != 1) begin
      bad++; $display("FAIL resume_in_issue: valid=%b op=%0d rd=%b reads=%0d want 1 5 0 1",
                      instr_valid, opcode, mem_rd, rd_count - rd0);
    end
  endtask

  task automatic test_jmp_stall();
    bit ok;
    int stall_bad;
    mem[0] = 8'hE9;
    mem[9] = 8'h65;
    do_reset();
    pulse_resume();
    wait_issue(ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL jmp_timeout: instr_valid=%b want 1", instr_valid);
    end
    stall_bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if ({instr_valid, opcode, operand, pc} !== {1'b1, 3'd7, 5'd9, 5'd1}) stall_bad++;
    end
    total++;
    if (stall_bad != 0) begin
      bad++; $display("FAIL jmp_stall: unstable cycles=%0d want 0 (now valid=%b op=%0d opd=%0d)",
                      stall_bad, instr_valid, opcode, operand);
    end
    handshake(1'b0);
    total++;
    if ({mem_rd, mem_addr} !== {1'b1, 5'd9}) begin
      bad++; $display("FAIL jmp_target: rd=%b addr=%0d want 1 9", mem_rd, mem_addr);
    end
    @(negedge clk);
    total++;
    if ({instr_valid, mem_rd} !== 2'b00) begin
      bad++; $display("FAIL jmp_wait: valid=%b rd=%b want 0 0", instr_valid, mem_rd);
    end
    @(negedge clk);
    total++;
    if ({instr_valid, opcode, operand, pc} !== {1'b1, 3'd3, 5'd5, 5'd10}) begin
      bad++; $display("FAIL issue_latency: valid=%b op=%0d opd=%0d pc=%0d want 1 3 5 10",
                      instr_valid, opcode, operand, pc);
    end
  endtask

  task automatic run_skz(input logic acc, input logic [4:0] want);
    bit ok;
    mem[0] = 8'hE4;
    mem[4] = 8'h20;
    do_reset();
    pulse_resume();
    wait_issue(ok);
    handshake(1'b1);
    wait_issue(ok);
    total++;
    if (!ok || {opcode, pc} !== {3'd1, 5'd5}) begin
      bad++; $display("FAIL skz_issue: ok=%b op=%0d pc=%0d want 1 1 5", ok, opcode, pc);
    end
    handshake(acc);
    total++;
    if ({mem_rd, mem_addr} !== {1'b1, want}) begin
      bad++; $display("FAIL skz_acc%0d: rd=%b addr=%0d want 1 %0d", acc, mem_rd, mem_addr, want);
    end
  endtask

  task automatic test_skz();
    run_skz(1'b1, 5'd6);
    run_skz(1'b0, 5'd5);
  endtask

  task automatic test_halt();
    bit ok;
    int rd0;
    mem[0] = 8'hE7;
    mem[7] = 8'h00;
    mem[8] = 8'hA3;
    do_reset();
    pulse_resume();
    wait_issue(ok);
    handshake(1'b0);
    wait_issue(ok);
    total++;
    if (!ok || opcode !== 3'd0) begin
      bad++; $display("FAIL hlt_issue: ok=%b op=%0d want 1 0", ok, opcode);
    end
    handshake(1'b0);
    total++;
    if ({halted, instr_valid, mem_rd, pc} !== {3'b100, 5'd8}) begin
      bad++; $display("FAIL halt_state: halted=%b valid=%b rd=%b pc=%0d want 1 0 0 8",
                      halted, instr_valid, mem_rd, pc);
    end
    // stray rvalid while halted must not touch IR or pc
    rd0 = rd_count;
    force_rdata = 8'hFF;
    force_rvalid = 1'b1;
    @(negedge clk);
    force_rvalid = 1'b0;
    @(negedge clk);
    total++;
    if ({halted, opcode, operand, pc} !== {1'b1, 3'd0, 5'd0, 5'd8} || rd_count != rd0) begin
      bad++; $display("FAIL halt_stray_rvalid: halted=%b op=%0d opd=%0d pc=%0d want 1 0 0 8",
                      halted, opcode, operand, pc);
    end
    pulse_resume();
    total++;
    if ({mem_rd, mem_addr, halted} !== {1'b1, 5'd8, 1'b0}) begin
      bad++; $display("FAIL halt_resume: rd=%b addr=%0d halted=%b want 1 8 0", mem_rd, mem_addr, halted);
    end
    wait_issue(ok);
    total++;
    if (!ok || {opcode, operand, pc} !== {3'd5, 5'd3, 5'd9}) begin
      bad++; $display("FAIL halt_refetch: ok=%b op=%0d opd=%0d pc=%0d want 1 5 3 9", ok, opcode, operand, pc);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    mem[0]  = 8'hFF;
    mem[31] = 8'h41;
    do_reset();
    pulse_resume();
    wait_issue(ok);
    handshake(1'b0);
    wait_issue(ok);
    total++;
    if (!ok || {opcode, operand, pc} !== {3'd2, 5'd1, 5'd0}) begin
      bad++; $display("FAIL wrap_inc: ok=%b op=%0d opd=%0d pc=%0d want 1 2 1 0", ok, opcode, operand, pc);
    end
    handshake(1'b0);
    total++;
    if ({mem_rd, mem_addr} !== {1'b1, 5'd0}) begin
      bad++; $display("FAIL wrap_fetch: rd=%b addr=%0d want 1 0", mem_rd, mem_addr);
    end
    mem[0]  = 8'hFE;
    mem[30] = 8'h20;
    do_reset();
    pulse_resume();
    wait_issue(ok);
    handshake(1'b0);
    wait_issue(ok);
    total++;
    if (!ok || {opcode, pc} !== {3'd1, 5'd31}) begin
      bad++; $display("FAIL wrap_skz_issue: ok=%b op=%0d pc=%0d want 1 1 31", ok, opcode, pc);
    end
    handshake(1'b1);
    total++;
    if ({mem_rd, mem_addr} !== {1'b1, 5'd0}) begin
      bad++; $display("FAIL wrap_skz: rd=%b addr=%0d want 1 0", mem_rd, mem_addr);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    mem[0] = 8'hA3;
    mem_auto = 1'b0;
    do_reset();
    pulse_resume();
    repeat (3) @(negedge clk);
    total++;
    if ({instr_valid, mem_rd, halted, pc} !== {3'b000, 5'd0}) begin
      bad++; $display("FAIL wait_hold: valid=%b rd=%b halted=%b pc=%0d want 0 0 0 0",
                      instr_valid, mem_rd, halted, pc);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    force_rdata = 8'hFF;
    force_rvalid = 1'b1;
    repeat (2) @(negedge clk);
    force_rvalid = 1'b0;
    total++;
    if ({instr_valid, halted, mem_rd} !== 3'b010 || {opcode, operand} !== 8'h00 || pc !== 5'd0) begin
      bad++; $display("FAIL reset_mid_wait: valid=%b halted=%b rd=%b ir=%h pc=%0d want 0 1 0 00 0",
                      instr_valid, halted, mem_rd, {opcode, operand}, pc);
    end
    // reset during ISSUE with ready high: no handshake side effects
    mem_auto = 1'b1;
    pulse_resume();
    wait_issue(ok);
    rst_n = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    instr_ready = 1'b0;
    total++;
    if ({instr_valid, halted, mem_rd, pc} !== {3'b010, 5'd0}) begin
      bad++; $display("FAIL reset_in_issue: valid=%b halted=%b rd=%b pc=%0d want 0 1 0 0",
                      instr_valid, halted, mem_rd, pc);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h40;
    test_reset();
    test_first_fetch();
    test_jmp_stall();
    test_skz();
    test_halt();
    test_wrap();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
